flp_frac_split_seq: RTL and testbench

//  Iterative float-to-fixed splitter for the FLP_TO_DECIMAL path. Takes a biased exponent
//  and a hidden-bit fraction, aligns the fraction with a multi-cycle logarithmic shifter,
//  and returns the integer part Q and the binary fraction part R of |value|.
//  It also returns sticky, overflow and zero flags. Both sides use valid/ready

---
 rtl/flp_frac_split_seq.sv | 206 ++++++++++++++++++++
 tb/tb_flp_frac_split_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_frac_split_seq.sv
// ============================================================================
// Module      : flp_frac_split_seq
// Description : Iterative float-to-fixed splitter that returns integer and
//               binary-fraction parts of |value| via a multi-cycle log shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flp_frac_split_seq #(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] q,
    output logic [FRAC_W-1:0] r,
    output logic              sign_out,
    output logic              sticky,
    output logic              ovf,
    output logic              zero
);

    localparam int SH_BITS = $clog2(FRAC_W + 1);
    localparam int SHW     = EXP_W + 2;
    localparam int WW      = 2 * FRAC_W;

    localparam logic [SHW-1:0]     BIAS_M1  = SHW'(BIAS - 1);
    localparam logic [SHW-1:0]     FRAC_W_S = SHW'(FRAC_W);
    localparam logic [SH_BITS-1:0] CNT_LAST = SH_BITS'(SH_BITS - 1);
    localparam logic [SH_BITS-1:0] MAG_MAX  = SH_BITS'(FRAC_W);
    localparam logic [WW-1:0]      W_ONE    = WW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SH_BITS-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]       w_q, w_d;
    logic                dir_q, dir_d;
    logic [SH_BITS-1:0]  mag_q, mag_d;
    logic                stk_q, stk_d;
    logic                sign_q, sign_d;
    logic                ovfl_q, ovfl_d;
    logic                zerol_q, zerol_d;
    logic [FRAC_W-1:0]   q_q, q_d;
    logic [FRAC_W-1:0]   r_q, r_d;
    logic                sign_out_q, sign_out_d;
    logic                sticky_q, sticky_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;

    logic [SHW-1:0]      sh;
    logic [SHW-1:0]      sh_abs;
    logic                sh_neg;
    logic [SH_BITS-1:0]  mag_load;
    int unsigned         w_amt;
    logic [WW-1:0]       w_mask;
    logic [WW-1:0]       w_step;
    logic                stk_step;

    // Two's-complement sh = in_exp - BIAS + 1; sign bit selects right shift.
    assign sh       = {2'b00, in_exp} - BIAS_M1;
    assign sh_neg   = sh[SHW-1];
    assign sh_abs   = sh_neg ? (~sh + 1'b1) : sh;
    assign mag_load = (sh_abs > FRAC_W_S) ? MAG_MAX : sh_abs[SH_BITS-1:0];

    assign w_amt  = 32'd1 << cnt_q;
    assign w_mask = (W_ONE << w_amt) - W_ONE;

    always_comb begin
        w_step   = w_q;
        stk_step = stk_q;
        if (mag_q[cnt_q]) begin
            if (dir_q) begin
                w_step   = w_q >> w_amt;
                stk_step = stk_q | (|(w_q & w_mask));
            end else begin
                w_step = w_q << w_amt;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        dir_d      = dir_q;
        mag_d      = mag_q;
        stk_d      = stk_q;
        sign_d     = sign_q;
        ovfl_d     = ovfl_q;
        zerol_d    = zerol_q;
        q_d        = q_q;
        r_d        = r_q;
        sign_out_d = sign_out_q;
        sticky_d   = sticky_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    w_d     = {{FRAC_W{1'b0}}, in_frac};
                    dir_d   = sh_neg;
                    mag_d   = mag_load;
                    stk_d   = 1'b0;
                    sign_d  = in_sign;
                    ovfl_d  = (&in_exp) | (!sh_neg && (sh > FRAC_W_S));
                    zerol_d = (in_exp == '0);
                end
            end
            S_SHIFT: begin
                w_d   = w_step;
                stk_d = stk_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Result registers load only here so they hold across IDLE.
                    state_d    = S_DONE;
                    cnt_d      = '0;
                    sign_out_d = sign_q;
                    ovf_d      = ovfl_q;
                    zero_d     = zerol_q;
                    if (ovfl_q) begin
                        q_d      = '1;
                        r_d      = '0;
                        sticky_d = stk_step;
                    end else if (zerol_q) begin
                        q_d      = '0;
                        r_d      = '0;
                        sticky_d = 1'b0;
                    end else begin
                        q_d      = w_step[WW-1:FRAC_W];
                        r_d      = w_step[FRAC_W-1:0];
                        sticky_d = stk_step;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            w_q        <= '0;
            dir_q      <= 1'b0;
            mag_q      <= '0;
            stk_q      <= 1'b0;
            sign_q     <= 1'b0;
            ovfl_q     <= 1'b0;
            zerol_q    <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            sign_out_q <= 1'b0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            dir_q      <= dir_d;
            mag_q      <= mag_d;
            stk_q      <= stk_d;
            sign_q     <= sign_d;
            ovfl_q     <= ovfl_d;
            zerol_q    <= zerol_d;
            q_q        <= q_d;
            r_q        <= r_d;
            sign_out_q <= sign_out_d;
            sticky_q   <= sticky_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign sign_out  = sign_out_q;
    assign sticky    = sticky_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_flp_frac_split_seq.sv
// ============================================================================
// Module      : tb_flp_frac_split_seq
// Description : Self-checking bench for flp_frac_split_seq against an exact
//               wide-integer model of |frac * 2^(exp-BIAS-(FRAC_W-1))|.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flp_frac_split_seq;

    localparam int FRAC_W  = 24;
    localparam int EXP_W   = 8;
    localparam int BIAS    = 127;
    localparam int SH_BITS = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] q;
    logic [FRAC_W-1:0] r;
    logic              sign_out;
    logic              sticky;
    logic              ovf;
    logic              zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_q[$];
    int oh_q[$];

    flp_frac_split_seq #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .BIAS(BIAS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .sign_out(sign_out), .sticky(sticky), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Handshake log sampled mid-cycle, tagged with the current cycle number.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) oh_q.push_back(cyc);
    end

    // value * 2^160 as an exact integer; q is bits above 160, r the next 24.
    function automatic void model(input logic [7:0] e, input logic [23:0] f,
                                  output logic [23:0] mq, output logic [23:0] mr,
                                  output logic ms, output logic mo, output logic mz);
        logic [299:0] v;
        mq = '0; mr = '0; ms = 1'b0; mo = 1'b0; mz = 1'b0;
        if (e == 8'd0) begin
            mz = 1'b1;
        end else if (e == 8'hFF) begin
            mo = 1'b1; mq = '1;
        end else begin
            v = 300'(f) << (int'(e) + 10);
            if (v[299:184] != '0) begin
                mo = 1'b1; mq = '1;
            end else begin
                mq = v[183:160];
                mr = v[159:136];
                ms = |v[135:0];
            end
        end
    endfunction

    task automatic do_op(input logic [7:0] e, input logic [23:0] f, input logic s,
                         input int hold);
        logic [23:0] eq, er;
        logic es, eo, ez;
        int k;
        model(e, f, eq, er, es, eo, ez);
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL in_ready_idle: got %b want 1", in_ready);
        end
        in_valid = 1'b1; in_exp = e; in_frac = f; in_sign = s;
        @(posedge clk); #1;
        in_valid = 1'b0; in_exp = 8'($urandom); in_frac = 24'($urandom); in_sign = 1'($urandom);
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        n_tests++;
        if (k != SH_BITS) begin
            n_fail++; $display("FAIL latency exp=%0d: got %0d cycles want %0d", e, k, SH_BITS);
        end
        n_tests++;
        if (q !== eq || r !== er) begin
            n_fail++; $display("FAIL qr exp=%0d frac=%h: got q=%h r=%h want q=%h r=%h",
                               e, f, q, r, eq, er);
        end
        n_tests++;
        if (sticky !== es || ovf !== eo || zero !== ez || sign_out !== s) begin
            n_fail++; $display("FAIL flags exp=%0d frac=%h: got s/o/z/sg=%b%b%b%b want %b%b%b%b",
                               e, f, sticky, ovf, zero, sign_out, es, eo, ez, s);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== eq || r !== er || sticky !== es) begin
                n_fail++; $display("FAIL hold_stable cyc=%0d: got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h",
                                   i, out_valid, in_ready, q, r, eq, er);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || q !== eq || r !== er || ovf !== eo) begin
            n_fail++; $display("FAIL post_handshake: got v=%b q=%h r=%h want v=0 q=%h r=%h",
                               out_valid, q, r, eq, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_frac = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || q !== '0 || r !== '0 ||
            sign_out !== 1'b0 || sticky !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got rdy=%b v=%b q=%h r=%h flags=%b%b%b%b want all 0",
                               in_ready, out_valid, q, r, sign_out, sticky, ovf, zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(8'd127, 24'h800000, 1'b0, 0);
        do_op(8'd128, 24'hA00000, 1'b1, 0);
        do_op(8'd126, 24'hC00000, 1'b0, 1);
        do_op(8'd103, 24'h800000, 1'b0, 0);
        do_op(8'd97,  24'h800001, 1'b1, 0);
        do_op(8'd150, 24'h800000, 1'b0, 0);
        do_op(8'd151, 24'h800000, 1'b0, 0);
        do_op(8'd152, 24'hC00000, 1'b1, 0);
        do_op(8'hFF,  24'h812345, 1'b0, 0);
        do_op(8'd0,   24'hFFFFFF, 1'b1, 0);
        do_op(8'd102, 24'hFFFFFF, 1'b0, 0);
    endtask

    task automatic test_stall();
        do_op(8'd140, 24'hABCDEF, 1'b1, 10);
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       e = 8'd0;
                1:       e = 8'hFF;
                2:       e = 8'($urandom_range(1, 254));
                default: e = 8'($urandom_range(95, 155));
            endcase
            do_op(e, {1'b1, 23'($urandom)}, 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] eq, er;
        logic es, eo, ez;
        int k;
        model(8'd131, 24'hF0F0F1, eq, er, es, eo, ez);
        acc_q.delete(); oh_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b1; in_exp = 8'd129; in_frac = 24'h900000; in_sign = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_exp = 8'd131; in_frac = 24'hF0F0F1; in_sign = 1'b1;
        k = 0;
        while (acc_q.size() < 2 && k < 30) begin
            @(posedge clk); #1; k++;
        end
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        n_tests++;
        if (out_valid !== 1'b1 || q !== eq || r !== er || sticky !== es || sign_out !== 1'b1) begin
            n_fail++; $display("FAIL b2b_result: got v=%b q=%h r=%h s=%b want v=1 q=%h r=%h s=%b",
                               out_valid, q, r, sticky, eq, er, es);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 2 || oh_q.size() < 1) begin
            n_fail++; $display("FAIL b2b_handshakes: got acc=%0d oh=%0d want acc=2 oh>=1",
                               acc_q.size(), oh_q.size());
        end else begin
            n_tests++;
            if (acc_q[1] != oh_q[0] + 1) begin
                n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_q[1], oh_q[0] + 1);
            end
            n_tests++;
            if (acc_q[1] - acc_q[0] != SH_BITS + 2) begin
                n_fail++; $display("FAIL b2b_throughput: got %0d want %0d",
                                   acc_q[1] - acc_q[0], SH_BITS + 2);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        do_op(8'd128, 24'hA00000, 1'b1, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_exp = 8'd135; in_frac = 24'hFFFFFF; in_sign = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || q !== '0 || r !== '0 ||
            sign_out !== 1'b0 || sticky !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_shift: got rdy=%b v=%b q=%h r=%h flags=%b%b%b%b want all 0",
                               in_ready, out_valid, q, r, sign_out, sticky, ovf, zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL reset_abort: got %0d valid cycles want 0", seen);
        end
        do_op(8'd133, 24'hC80000, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
